// File: rtl/mips_mem_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// FSM state encoding and requester port indices.
package mips_mem_pkg;

    localparam int ADDR_W_DEFAULT = 18;
    localparam int DATA_W_DEFAULT = 32;
    localparam int NUM_PORTS      = 2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection between the fetch and data ports (one-hot grant out).
// MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise port 1 always wins.
module mem_arb_picker
    import mips_mem_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last_grant,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that was not served last goes first.
    always_comb begin
        grant = '0;
        if (req[PORT_IF] && req[PORT_DM]) begin
            if (last_grant == PORT_DM) begin
                grant[PORT_IF] = 1'b1;
            end else begin
                grant[PORT_DM] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = '0;
        if (req[PORT_DM]) begin
            grant[PORT_DM] = 1'b1;
        end else if (req[PORT_IF]) begin
            grant[PORT_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-cycle memory_block.
// Arbitration policy is chosen by MEM_ARB_ROUND_ROBIN_EN (undefined: fixed priority to port 1).
module memory_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_byte,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_byteOperations,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic              busy
);

    arb_state_t           state_reg;
    arb_state_t           state_next;
    logic                 take_grant;
    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [NUM_PORTS-1:0] ack_vec;
    logic                 last_grant;

    logic                 winner_reg;
    logic                 we_reg;
    logic                 byte_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [DATA_W-1:0]    if_rdata_reg;
    logic [DATA_W-1:0]    dm_rdata_reg;

    assign req_vec = {dm_req, if_req};

    mem_arb_picker u_picker (
        .req        (req_vec),
        .last_grant (last_grant),
        .grant      (grant_vec)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_reg;

    // Reset points at port 1 so the first tie after reset goes to port 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= PORT_DM;
        end else if (take_grant) begin
            last_grant_reg <= grant_vec[PORT_DM];
        end
    end

    assign last_grant = last_grant_reg;
`else
    assign last_grant = PORT_DM;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Strobes are decoded from registered state so reset drops them at once.
    always_comb begin
        state_next         = state_reg;
        take_grant         = 1'b0;
        mem_address        = '0;
        mem_write_data     = '0;
        mem_byteOperations = 1'b0;
        mem_memRead        = 1'b0;
        mem_memWrite       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    take_grant = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_address        = addr_reg;
                mem_write_data     = wdata_reg;
                mem_byteOperations = byte_reg;
                mem_memWrite       = we_reg;
                mem_memRead        = ~we_reg;
                state_next         = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_reg != ST_IDLE);

    // Operands are latched at grant so the requester may drop req afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner_reg <= PORT_DM;
            we_reg     <= 1'b0;
            byte_reg   <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else if (take_grant) begin
            if (grant_vec[PORT_DM]) begin
                winner_reg <= PORT_DM;
                we_reg     <= dm_we;
                byte_reg   <= dm_byte;
                addr_reg   <= dm_addr;
                wdata_reg  <= dm_wdata;
            end else if (grant_vec[PORT_IF]) begin
                winner_reg <= PORT_IF;
                we_reg     <= 1'b0;
                byte_reg   <= 1'b0;
                addr_reg   <= if_addr;
                wdata_reg  <= '0;
            end
        end
    end

    // Read data is captured at the end of ACCESS and held until that port's next DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
        end else if (state_reg == ST_ACCESS) begin
            if (winner_reg == PORT_IF) begin
                if_rdata_reg <= mem_read_data;
            end else begin
                dm_rdata_reg <= we_reg ? '0 : mem_read_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == ST_DONE) && (winner_reg == 1'(gi));
        end
    endgenerate

    assign if_ack   = ack_vec[PORT_IF];
    assign dm_ack   = ack_vec[PORT_DM];
    assign if_rdata = if_rdata_reg;
    assign dm_rdata = dm_rdata_reg;

endmodule
